// File: rtl/cleaning_action_scheduler.sv
// Action gate for the pipe-cleaning robot: grants moves against a movement budget,
// stretches trash removal into timed attempts with barrier re-checks, and flags spin/stall aborts.
module cleaning_action_scheduler #(
  parameter int MOVE_W        = 9,
  parameter int REMOVE_CYCLES = 3,
  parameter int MAX_RETRIES   = 2,
  parameter int TURN_LIMIT    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [MOVE_W-1:0] max_moves,
  input  logic              req_front,
  input  logic              req_turn,
  input  logic              req_remove,
  input  logic              barrier,
  output logic              act_front,
  output logic              act_turn,
  output logic              act_remove,
  output logic              busy,
  output logic              done,
  output logic              stuck,
  output logic [MOVE_W-1:0] moves_left
);

  localparam int REM_W   = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int TURN_W  = $clog2(TURN_LIMIT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_REMOVE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_STUCK  = 3'd5;

  localparam logic [REM_W-1:0]   REM_LOAD  = REM_W'(REMOVE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [TURN_W-1:0]  TURN_MAX  = TURN_W'(TURN_LIMIT);

  logic [2:0]         state_q, state_d;
  logic [MOVE_W-1:0]  moves_q, moves_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TURN_W-1:0]  turn_q, turn_d;

  logic              grant_front;
  logic              grant_turn;
  logic [MOVE_W-1:0] moves_dec;
  logic [TURN_W-1:0] turn_inc;

  // Grants are combinational so the robot FSM sees them in the request cycle.
  assign grant_front = (state_q == S_RUN) & req_front & ~req_remove;
  assign grant_turn  = (state_q == S_RUN) & req_turn & ~req_front & ~req_remove;
  assign moves_dec   = (moves_q != '0) ? moves_q - MOVE_W'(1) : '0;
  assign turn_inc    = turn_q + TURN_W'(1);

  always_comb begin
    state_d = state_q;
    moves_d = moves_q;
    rem_d   = rem_q;
    retry_d = retry_q;
    turn_d  = turn_q;
    case (state_q)
      S_IDLE, S_DONE, S_STUCK: begin
        if (start) begin
          moves_d = max_moves;
          rem_d   = '0;
          retry_d = '0;
          turn_d  = '0;
          state_d = (max_moves == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (req_remove) begin
          moves_d = moves_dec;
          turn_d  = '0;
          retry_d = '0;
          rem_d   = REM_LOAD;
          state_d = S_REMOVE;
        end else if (grant_front || grant_turn) begin
          moves_d = moves_dec;
          turn_d  = grant_front ? '0 : turn_inc;
          // A spin abort outranks running out of budget on the same edge.
          if (grant_turn && (turn_inc == TURN_MAX)) begin
            state_d = S_STUCK;
          end else if (moves_q == MOVE_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_REMOVE: begin
        if (rem_q == '0) begin
          state_d = S_CHECK;
        end else begin
          rem_d = rem_q - REM_W'(1);
        end
      end
      S_CHECK: begin
        if (!barrier) begin
          state_d = (moves_q == '0) ? S_DONE : S_RUN;
        end else if (retry_q < RETRY_MAX) begin
          // Retries reuse the move already paid for the first attempt.
          retry_d = retry_q + RETRY_W'(1);
          rem_d   = REM_LOAD;
          state_d = S_REMOVE;
        end else begin
          state_d = S_STUCK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      moves_q <= '0;
      rem_q   <= '0;
      retry_q <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      moves_q <= moves_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      turn_q  <= turn_d;
    end
  end

  assign act_front  = grant_front;
  assign act_turn   = grant_turn;
  assign act_remove = (state_q == S_REMOVE);
  assign busy       = (state_q == S_RUN) | (state_q == S_REMOVE) | (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign stuck      = (state_q == S_STUCK);
  assign moves_left = moves_q;

endmodule

// File: tb/tb_cleaning_action_scheduler.sv
// Scoreboard bench: stimulus pushes expected outputs from a mission-level model,
// a negedge monitor pops and compares them against the scheduler.
module tb_cleaning_action_scheduler;

  localparam int MOVE_W        = 9;
  localparam int REMOVE_CYCLES = 3;
  localparam int MAX_RETRIES   = 2;
  localparam int TURN_LIMIT    = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [MOVE_W-1:0] max_moves;
  logic              req_front, req_turn, req_remove, barrier;
  logic              act_front, act_turn, act_remove, busy, done, stuck;
  logic [MOVE_W-1:0] moves_left;

  always #5 clock = ~clock;

  cleaning_action_scheduler #(
    .MOVE_W(MOVE_W), .REMOVE_CYCLES(REMOVE_CYCLES),
    .MAX_RETRIES(MAX_RETRIES), .TURN_LIMIT(TURN_LIMIT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .max_moves(max_moves),
    .req_front(req_front), .req_turn(req_turn), .req_remove(req_remove),
    .barrier(barrier), .act_front(act_front), .act_turn(act_turn),
    .act_remove(act_remove), .busy(busy), .done(done), .stuck(stuck),
    .moves_left(moves_left)
  );

  typedef struct packed {
    logic              f;
    logic              t;
    logic              r;
    logic              bsy;
    logic              dn;
    logic              stk;
    logic [MOVE_W-1:0] mv;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Mission-level reference: phase of the mission plus budget, spin count,
  // remaining actuator cycles of this attempt and attempts made so far.
  localparam int P_IDLE = 0, P_RUN = 1, P_REMOVE = 2, P_CHECK = 3, P_DONE = 4, P_STUCK = 5;
  int phase    = P_IDLE;
  int budget   = 0;
  int spins    = 0;
  int hold     = 0;
  int attempts = 0;

  function automatic obs_t sample_dut();
    obs_t a;
    a.f = act_front; a.t = act_turn; a.r = act_remove;
    a.bsy = busy; a.dn = done; a.stk = stuck; a.mv = moves_left;
    return a;
  endfunction

  function automatic obs_t model_out(input logic rf, input logic rt, input logic rr);
    obs_t o;
    o.f   = (phase == P_RUN) && rf && !rr;
    o.t   = (phase == P_RUN) && rt && !rf && !rr;
    o.r   = (phase == P_REMOVE);
    o.bsy = (phase == P_RUN) || (phase == P_REMOVE) || (phase == P_CHECK);
    o.dn  = (phase == P_DONE);
    o.stk = (phase == P_STUCK);
    o.mv  = MOVE_W'(budget);
    return o;
  endfunction

  task automatic model_advance(input logic s, input int mm, input logic rf,
                               input logic rt, input logic rr, input logic b);
    case (phase)
      P_IDLE, P_DONE, P_STUCK: begin
        if (s) begin
          budget = mm; spins = 0; hold = 0; attempts = 0;
          phase = (mm == 0) ? P_DONE : P_RUN;
        end
      end
      P_RUN: begin
        if (rr) begin
          if (budget > 0) budget--;
          spins = 0; attempts = 1; hold = REMOVE_CYCLES;
          phase = P_REMOVE;
        end else if (rf || rt) begin
          if (budget > 0) budget--;
          if (rf) spins = 0; else spins++;
          if (spins == TURN_LIMIT) phase = P_STUCK;
          else if (budget == 0) phase = P_DONE;
        end
      end
      P_REMOVE: begin
        hold--;
        if (hold == 0) phase = P_CHECK;
      end
      P_CHECK: begin
        if (!b) phase = (budget == 0) ? P_DONE : P_RUN;
        else if (attempts < 1 + MAX_RETRIES) begin
          attempts++; hold = REMOVE_CYCLES; phase = P_REMOVE;
        end else phase = P_STUCK;
      end
      default: phase = P_IDLE;
    endcase
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = sample_dut();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_check %0d: got f=%0b t=%0b r=%0b busy=%0b done=%0b stuck=%0b moves=%0d, required f=%0b t=%0b r=%0b busy=%0b done=%0b stuck=%0b moves=%0d",
                 checks, a.f, a.t, a.r, a.bsy, a.dn, a.stk, a.mv,
                 e.f, e.t, e.r, e.bsy, e.dn, e.stk, e.mv);
      end else begin
        $display("check %0d ok: f=%0b t=%0b r=%0b busy=%0b done=%0b stuck=%0b moves=%0d",
                 checks, a.f, a.t, a.r, a.bsy, a.dn, a.stk, a.mv);
      end
    end
  end

  task automatic check_now(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end else begin
      $display("check %0d ok: %s = %0d", checks, name, got);
    end
  endtask

  // One clock cycle of stimulus; called at posedge+1.
  task automatic step(input logic s, input int mm, input logic rf, input logic rt,
                      input logic rr, input logic b);
    start = s; max_moves = MOVE_W'(mm);
    req_front = rf; req_turn = rt; req_remove = rr; barrier = b;
    exp_q.push_back(model_out(rf, rt, rr));
    model_advance(s, mm, rf, rt, rr, b);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_steps(input int n, input logic rf, input logic rt,
                            input logic rr, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, 0, rf, rt, rr, b);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; max_moves = '0;
    req_front = 1'b0; req_turn = 1'b0; req_remove = 1'b0; barrier = 1'b0;
    #1;
    check_now("reset_busy", int'(busy), 0);
    check_now("reset_moves", int'(moves_left), 0);
    check_now("reset_acts", int'({act_front, act_turn, act_remove, done, stuck}), 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Budget run-out with constant forward requests.
    step(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_steps(7, 1'b1, 1'b0, 1'b0, 1'b0);
    // Spin loop.
    step(1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_steps(6, 1'b0, 1'b1, 1'b0, 1'b0);
    // Removal cleared on first attempt.
    step(1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_steps(5, 1'b0, 1'b0, 1'b0, 1'b0);
    // Barrier never clears.
    step(1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_steps(14, 1'b0, 1'b0, 1'b0, 1'b1);
    // Zero budget, then restart.
    step(1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_steps(4, 1'b1, 1'b1, 1'b0, 1'b0);
    // Both front and turn requested; start while busy must be ignored.
    step(1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_steps(2, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a removal.
    step(1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    check_now("midremove_act_remove", int'(act_remove), 0);
    check_now("midremove_busy", int'(busy), 0);
    check_now("midremove_moves", int'(moves_left), 0);
    phase = P_IDLE; budget = 0; spins = 0; hold = 0; attempts = 0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    idle_steps(3, 1'b1, 1'b0, 1'b1, 1'b1);

    // Randomised missions.
    for (int i = 0; i < 500; i++) begin
      logic s;
      bit   idle_like;
      idle_like = (phase == P_IDLE) || (phase == P_DONE) || (phase == P_STUCK);
      s = idle_like ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      step(s, int'($urandom_range(0, 12)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end

    @(negedge clock); #1;
    check_now("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
